tx_frame_serializer: RTL and testbench
======================================

Name: tx_frame_serializer

Overview:
- Transmit-path stage directly downstream of the TX address register.
- On a start request, snapshots the registered 96-bit address and a 16-bit EtherType/length.
- Emits a byte-wide AXI-Stream frame toward the tri-mode Ethernet MAC: 6 destination bytes, 6 source bytes, 2 type bytes, then payload bytes from the pattern/payload source.
- Zero-pads short payloads to the Ethernet minimum and truncates oversize payloads.

Parameters:
- MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded up to this count.
- MAX_PAYLOAD, 1500, maximum payload bytes forwarded; any excess is discarded.
- PAD_EN, 1, 1 = pad short payloads; 0 = end the frame at s_tlast with no padding.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle frame request; honoured only in IDLE.
- tx_address  in  96  address type from the shared package: dst = [95:48], src = [47:0].
- ether_type  in  16  EtherType/length field, sent MSB byte first.
- s_tdata  in  8  payload byte.
- s_tvalid  in  1  payload valid.
- s_tready  out  1  payload ready.
- s_tlast  in  1  last payload byte.
- m_tdata  out  8  frame byte to the MAC.
- m_tvalid  out  1  frame byte valid.
- m_tready  in  1  MAC ready.
- m_tlast  out  1  last frame byte.
- busy  out  1  high from an accepted start until the frame completes.
- done  out  1  one-cycle pulse when the frame completes.
- err_oversize  out  1  one-cycle pulse when a frame is truncated at MAX_PAYLOAD.

Behaviour:
- Reset (asynchronous, effective immediately):
  - state = IDLE; all counters and snapshot registers = 0.
  - m_tvalid = 0, m_tdata = 0, m_tlast = 0, s_tready = 0.
  - busy = 0, done = 0, err_oversize = 0.
- Output stage:
  - m_tdata, m_tvalid and m_tlast are registered.
  - A new byte is loaded only when m_tvalid = 0 or m_tready = 1 (call this "adv").
  - While m_tvalid = 1 and m_tready = 0, m_tdata and m_tlast hold stable.
- FSM states: IDLE, HEADER, PAYLOAD, PAD, DRAIN.
- IDLE:
  - On start = 1: latch tx_address and ether_type into the snapshot, hdr_cnt = 0, go to HEADER, busy = 1.
  - First header byte is valid on m_tvalid in the cycle after start (latency 1).
- HEADER:
  - On each adv, emit snapshot byte hdr_cnt. Bytes 0..5 = dst MSB first; bytes 6..11 = src MSB first; bytes 12..13 = ether_type[15:8], then ether_type[7:0].
  - After byte 13 is loaded, go to PAYLOAD with pay_cnt = 0.
  - tx_address/ether_type changes after start have no effect on the frame in flight.
- PAYLOAD:
  - s_tready = adv (combinational); each s_tvalid & s_tready loads s_tdata and increments pay_cnt (16 bit).
  - s_tlast with pay_cnt+1 >= MIN_PAYLOAD, or PAD_EN = 0: set m_tlast on that byte and finish.
  - s_tlast with pay_cnt+1 < MIN_PAYLOAD and PAD_EN = 1: go to PAD, no tlast on that byte.
  - pay_cnt+1 == MAX_PAYLOAD without s_tlast: set m_tlast, pulse err_oversize, go to DRAIN.
  - A byte that is simultaneously the MAX_PAYLOAD-th byte and s_tlast is a normal finish with no error.
- PAD:
  - s_tready = 0.
  - On each adv, emit 0x00 and increment pay_cnt.
  - m_tlast is set on the byte where pay_cnt reaches MIN_PAYLOAD.
- DRAIN:
  - s_tready = 1; input bytes are discarded.
  - On an accepted s_tlast, the frame is complete.
- Finish:
  - The frame completes when the m_tlast byte is accepted (m_tvalid & m_tready & m_tlast), or when DRAIN accepts s_tlast, whichever is later.
  - Next cycle: done = 1 for one cycle, busy = 0, state = IDLE.
  - start asserted in the done cycle is honoured (back-to-back frames).
- start while busy is ignored; there is no queueing.
- s_tvalid = 0 mid-payload: the frame stalls and m_tvalid drops after the held byte is taken. No timeout.
- Reset mid-frame: the frame is aborted with no tlast; the downstream MAC discards it.
- Minimum frame on the stream = 14 + MIN_PAYLOAD bytes (60); FCS is appended by the MAC.

Decomposition:
- Shared defines package:
  - Existing address packed struct (dst, src), reused as is.
  - New constants: ETH_HDR_BYTES = 14, ETH_MIN_PAYLOAD = 46, ETH_MAX_PAYLOAD = 1500.
  - FSM state enum tx_ser_state_e.
- Natural sub-module: tx_axis_out_reg. It holds the one-deep registered output slice (data/valid/last with the adv rule) and is instantiated once.

Test Plan:
- Header order: tx_address = 0x0A0B0C0D0E0F_112233445566, ether_type = 0x0800, 46-byte payload 0x00..0x2D, m_tready = 1 -> m_tdata sequence 0A 0B 0C 0D 0E 0F 11 22 33 44 55 66 08 00 00..2D. Expect 60 beats, tlast on beat 60, done 1 cycle after, start→first valid latency 1.
- Padding: 10-byte payload 0xA0..0xA9 with s_tlast -> 14 header + A0..A9 + 36 × 0x00, tlast on beat 60. With PAD_EN = 0 -> 24 beats, tlast on 0xA9.
- Oversize: MAX_PAYLOAD = 64, 70-byte payload -> 78 beats, tlast on beat 78, err_oversize pulse. The remaining 6 input bytes are accepted and dropped; done only after the input s_tlast.
- Backpressure: m_tready toggling 1010…, s_tvalid random -> byte sequence identical to the no-stall case. m_tdata is stable whenever m_tvalid & !m_tready; no byte is lost or duplicated.
- Snapshot and start rules: change tx_address 3 cycles after start -> frame carries the old address. start pulsed mid-frame -> ignored. start in the done cycle -> second frame begins on the next cycle.
- Reset mid-payload: rst_n low asynchronously at payload byte 5 -> m_tvalid, busy, s_tready = 0 immediately. After release, a new start produces a correct complete frame.

Source files
------------

// File: rtl/tx_frame_serializer_pkg.sv
// Shared definitions for the transmit framing path: address layout,
// Ethernet framing constants and the serializer state encoding.
package tx_frame_serializer_pkg;

  // Registered TX address as produced by the address register stage.
  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
  } tx_address_t;

  localparam int ETH_HDR_BYTES   = 14;
  localparam int ETH_MIN_PAYLOAD = 46;
  localparam int ETH_MAX_PAYLOAD = 1500;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PAD     = 3'd3,
    ST_DRAIN   = 3'd4
  } tx_ser_state_e;

  // Header byte idx (0..13): dst MSB first, src MSB first, type MSB first.
  function automatic logic [7:0] hdr_byte(input tx_address_t addr,
                                          input logic [15:0] etype,
                                          input logic [3:0]  idx);
    logic [111:0] hdr;
    hdr = {addr.dst, addr.src, etype} << {idx, 3'b000};
    return hdr[111:104];
  endfunction

endpackage

// File: rtl/tx_frame_serializer_out_reg.sv
// One-deep registered AXI-Stream output slice. A new beat may be loaded
// whenever the slice is empty or its current beat is being accepted (adv);
// while a beat is stalled, data and last hold stable.
module tx_axis_out_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] d_data,
  input  logic       d_last,
  input  logic       m_tready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  output logic       m_tlast,
  output logic       adv
);

  assign adv = ~m_tvalid | m_tready;

  // Output beat register: refill or empty only on adv.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tdata  <= 8'h00;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (adv) begin
      m_tvalid <= load;
      if (load) begin
        m_tdata <= d_data;
        m_tlast <= d_last;
      end
    end
  end

endmodule

// File: rtl/tx_frame_serializer.sv
// Serializes one Ethernet frame (dst, src, type, payload) onto a byte-wide
// AXI-Stream toward the MAC, padding short payloads and truncating long ones.
//
// Handshake: on both streams a beat transfers on a rising clock edge where
// valid and ready are both high; a source holds valid and its data stable
// until that transfer; ready may depend combinationally on the other side
// (s_tready follows the output slice's adv while forwarding payload).
module tx_frame_serializer
  import tx_frame_serializer_pkg::*;
#(
  parameter int MIN_PAYLOAD = ETH_MIN_PAYLOAD,
  parameter int MAX_PAYLOAD = ETH_MAX_PAYLOAD,
  parameter bit PAD_EN      = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  tx_address_t   tx_address,
  input  logic [15:0]   ether_type,
  input  logic [7:0]    s_tdata,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic          s_tlast,
  output logic [7:0]    m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          busy,
  output logic          done,
  output logic          err_oversize,
  output tx_ser_state_e state_dbg
);

  localparam logic [15:0] MIN_CNT  = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_CNT  = 16'(MAX_PAYLOAD);
  localparam logic [3:0]  HDR_LAST = 4'(ETH_HDR_BYTES - 1);

  tx_ser_state_e state, state_n;
  tx_address_t   snap_addr, snap_addr_n;
  logic [15:0]   snap_type, snap_type_n;
  logic [3:0]    hdr_cnt, hdr_cnt_n;
  logic [15:0]   pay_cnt, pay_cnt_n;
  // last_loaded: the m_tlast beat of this frame is in (or through) the slice.
  // tail_acked: that beat has been accepted by the MAC.
  // in_closed: after truncation, the input s_tlast has been swallowed.
  logic          last_loaded, last_loaded_n;
  logic          tail_acked, tail_acked_n;
  logic          in_closed, in_closed_n;
  logic          done_r, done_n;
  logic          err_r, err_n;

  logic          load, d_last, adv;
  logic [7:0]    d_data;
  logic [15:0]   pay_inc;
  logic          s_acc, m_acc_last, out_ok, in_ok;

  tx_axis_out_reg u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .d_data   (d_data),
    .d_last   (d_last),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .adv      (adv)
  );

  assign pay_inc      = pay_cnt + 16'd1;
  assign s_acc        = s_tvalid & s_tready;
  assign m_acc_last   = m_tvalid & m_tready & m_tlast;
  assign out_ok       = tail_acked | m_acc_last;
  assign in_ok        = (state != ST_DRAIN) | in_closed | (s_acc & s_tlast);
  assign busy         = (state != ST_IDLE);
  assign done         = done_r;
  assign err_oversize = err_r;
  assign state_dbg    = state;

  // State and frame bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      snap_addr   <= '0;
      snap_type   <= '0;
      hdr_cnt     <= '0;
      pay_cnt     <= '0;
      last_loaded <= 1'b0;
      tail_acked  <= 1'b0;
      in_closed   <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state       <= state_n;
      snap_addr   <= snap_addr_n;
      snap_type   <= snap_type_n;
      hdr_cnt     <= hdr_cnt_n;
      pay_cnt     <= pay_cnt_n;
      last_loaded <= last_loaded_n;
      tail_acked  <= tail_acked_n;
      in_closed   <= in_closed_n;
      done_r      <= done_n;
      err_r       <= err_n;
    end
  end

  // Next-state, output-slice load and payload-side ready.
  always_comb begin
    state_n       = state;
    snap_addr_n   = snap_addr;
    snap_type_n   = snap_type;
    hdr_cnt_n     = hdr_cnt;
    pay_cnt_n     = pay_cnt;
    last_loaded_n = last_loaded;
    tail_acked_n  = tail_acked | (last_loaded & m_acc_last);
    in_closed_n   = in_closed;
    done_n        = 1'b0;
    err_n         = 1'b0;
    load          = 1'b0;
    d_data        = 8'h00;
    d_last        = 1'b0;
    s_tready      = 1'b0;

    case (state)
      ST_IDLE: begin
        // Byte 0 comes straight from the inputs so it is valid the cycle
        // after start; the rest of the header is taken from the snapshot.
        if (start) begin
          snap_addr_n   = tx_address;
          snap_type_n   = ether_type;
          load          = 1'b1;
          d_data        = hdr_byte(tx_address, ether_type, 4'd0);
          hdr_cnt_n     = 4'd1;
          pay_cnt_n     = '0;
          last_loaded_n = 1'b0;
          tail_acked_n  = 1'b0;
          in_closed_n   = 1'b0;
          state_n       = ST_HEADER;
        end
      end

      ST_HEADER: begin
        if (adv) begin
          load   = 1'b1;
          d_data = hdr_byte(snap_addr, snap_type, hdr_cnt);
          if (hdr_cnt == HDR_LAST) begin
            pay_cnt_n = '0;
            state_n   = ST_PAYLOAD;
          end else begin
            hdr_cnt_n = hdr_cnt + 4'd1;
          end
        end
      end

      ST_PAYLOAD: begin
        s_tready = adv & ~last_loaded;
        if (s_acc) begin
          load      = 1'b1;
          d_data    = s_tdata;
          pay_cnt_n = pay_inc;
          if (s_tlast) begin
            if (pay_inc >= MIN_CNT || !PAD_EN) begin
              d_last        = 1'b1;
              last_loaded_n = 1'b1;
            end else begin
              state_n = ST_PAD;
            end
          end else if (pay_inc == MAX_CNT) begin
            d_last        = 1'b1;
            last_loaded_n = 1'b1;
            err_n         = 1'b1;
            state_n       = ST_DRAIN;
          end
        end
      end

      ST_PAD: begin
        if (adv && !last_loaded) begin
          load      = 1'b1;
          pay_cnt_n = pay_inc;
          if (pay_inc == MIN_CNT) begin
            d_last        = 1'b1;
            last_loaded_n = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        // Excess payload is accepted and discarded up to its s_tlast.
        s_tready = ~in_closed;
        if (s_acc && s_tlast) in_closed_n = 1'b1;
      end

      default: state_n = ST_IDLE;
    endcase

    // Frame completes once the tail beat is out and the input side is closed.
    if (state != ST_IDLE && last_loaded && out_ok && in_ok) begin
      state_n       = ST_IDLE;
      done_n        = 1'b1;
      last_loaded_n = 1'b0;
      tail_acked_n  = 1'b0;
      in_closed_n   = 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Bench for tx_frame_serializer: DUT A (pad on, MAX 64) and DUT B (pad off,
// MAX 1500) share stimulus; sel picks which one a frame is sent to.
module tb_tx_frame_serializer;
  import tx_frame_serializer_pkg::*;

  localparam int BUDGET = 1000;
  localparam int NV     = 13;

  typedef struct {
    logic        sel;
    logic [95:0] addr;
    logic [15:0] etype;
    int          n_pay;
    logic [7:0]  base;
    bit          rnd;
    bit          tog;
    bit          chg_addr;
    bit          mid_start;
    int          exp_beats;
    int          exp_err;
  } vec_t;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, sel;
  tx_address_t   tx_address;
  logic [15:0]   ether_type;
  logic [7:0]    s_tdata;
  logic          s_tvalid, s_tlast, m_tready;

  logic          s_tready_a, m_tvalid_a, m_tlast_a, busy_a, done_a, err_a;
  logic          s_tready_b, m_tvalid_b, m_tlast_b, busy_b, done_b, err_b;
  logic [7:0]    m_tdata_a, m_tdata_b;
  tx_ser_state_e state_a, state_b;

  logic          s_tready_x, m_tvalid_x, m_tlast_x, busy_x, done_x, err_x;
  logic [7:0]    m_tdata_x;

  assign s_tready_x = sel ? s_tready_b : s_tready_a;
  assign m_tvalid_x = sel ? m_tvalid_b : m_tvalid_a;
  assign m_tlast_x  = sel ? m_tlast_b  : m_tlast_a;
  assign m_tdata_x  = sel ? m_tdata_b  : m_tdata_a;
  assign busy_x     = sel ? busy_b     : busy_a;
  assign done_x     = sel ? done_b     : done_a;
  assign err_x      = sel ? err_b      : err_a;

  tx_frame_serializer #(.MIN_PAYLOAD(46), .MAX_PAYLOAD(64), .PAD_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .tx_address(tx_address),
    .ether_type(ether_type), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready_a), .s_tlast(s_tlast), .m_tdata(m_tdata_a),
    .m_tvalid(m_tvalid_a), .m_tready(m_tready), .m_tlast(m_tlast_a),
    .busy(busy_a), .done(done_a), .err_oversize(err_a), .state_dbg(state_a)
  );

  tx_frame_serializer #(.MIN_PAYLOAD(46), .MAX_PAYLOAD(1500), .PAD_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .tx_address(tx_address),
    .ether_type(ether_type), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready_b), .s_tlast(s_tlast), .m_tdata(m_tdata_b),
    .m_tvalid(m_tvalid_b), .m_tready(m_tready), .m_tlast(m_tlast_b),
    .busy(busy_b), .done(done_b), .err_oversize(err_b), .state_dbg(state_b)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];   // {tlast, data}
  int checks = 0;
  int errors = 0;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame: header, then payload truncated to MAX and padded to 46.
  task automatic push_expected(input vec_t v);
    int max_p, n_fwd, n_out;
    bit pad_en;
    logic [111:0] hdr;
    logic [7:0] b;
    max_p  = v.sel ? 1500 : 64;
    pad_en = !v.sel;
    n_fwd  = (v.n_pay < max_p) ? v.n_pay : max_p;
    n_out  = (pad_en && n_fwd < 46) ? 46 : n_fwd;
    hdr    = {v.addr, v.etype};
    for (int i = 0; i < 14; i++) exp_q.push_back({1'b0, hdr[111 - 8*i -: 8]});
    for (int i = 0; i < n_out; i++) begin
      b = (i < n_fwd) ? v.base + 8'(i) : 8'h00;
      exp_q.push_back({(i == n_out - 1), b});
    end
  endtask

  // ---------------- driver / monitor ----------------
  // Entered and left at negedge+1; returns in the done cycle (or after an abort).
  task automatic run_frame(input vec_t v, input int abort_at);
    int si, beats, errs, fin, c;
    bit offered, held, got_done, aborted;
    logic [8:0] prev_out, exp_b;
    push_expected(v);
    sel = v.sel;
    #0;
    chk("idle_at_start", busy_x, 1'b0);
    tx_address = v.addr;
    ether_type = v.etype;
    start = 1'b1;
    si = 0; offered = 0; beats = 0; errs = 0; fin = -1; c = 0;
    held = 0; got_done = 0; aborted = 0; prev_out = '0;
    while (c < BUDGET && !got_done && !aborted) begin
      @(negedge clk);
      c++;
      start = (v.mid_start && c == 20);
      if (v.chg_addr && c == 3) begin
        tx_address = ~v.addr;
        ether_type = ~v.etype;
      end
      if (si < v.n_pay) begin
        if (!offered) offered = v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        s_tvalid = offered;
        s_tdata  = v.base + 8'(si);
        s_tlast  = (si == v.n_pay - 1);
      end else begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end
      m_tready = v.tog ? c[0] : 1'b1;
      #1;
      if (c == 1) chk("start_latency", m_tvalid_x, 1'b1);
      if (held) chk("hold_stable", {m_tlast_x, m_tdata_x}, prev_out);
      if (s_tvalid && s_tready_x) begin
        if (s_tlast && c > fin) fin = c;
        si++;
        offered = 0;
      end
      if (m_tvalid_x && m_tready) begin
        beats++;
        if (exp_q.size() == 0) begin
          chk("extra_beat", beats, v.exp_beats);
        end else begin
          exp_b = exp_q.pop_front();
          chk("beat", {m_tlast_x, m_tdata_x}, exp_b);
        end
        if (m_tlast_x && c > fin) fin = c;
      end
      if (err_x) errs++;
      if (done_x) begin
        got_done = 1;
        chk("done_timing", c, fin + 1);
        chk("busy_in_done", busy_x, 1'b0);
      end
      held     = m_tvalid_x & ~m_tready;
      prev_out = {m_tlast_x, m_tdata_x};
      if (abort_at != 0 && beats == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_tvalid", m_tvalid_x, 1'b0);
        chk("reset_mid_busy", busy_x, 1'b0);
        chk("reset_mid_tready", s_tready_x, 1'b0);
        aborted = 1;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    start    = 1'b0;
    if (!aborted) begin
      chk("frame_done_seen", got_done, 1'b1);
      chk("beat_count", beats, v.exp_beats);
      chk("oversize_pulses", errs, v.exp_err);
      chk("queue_empty", exp_q.size(), 0);
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    #1;
    chk("idle_after", {busy_x, done_x}, 2'b00);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0]  = '{1'b0, 96'h0A0B0C0D0E0F_112233445566, 16'h0800, 46, 8'h00, 0, 0, 0, 0, 60, 0};
    tbl[1]  = '{1'b0, 96'h020000000001_020000000002, 16'h88B5, 10, 8'hA0, 0, 0, 0, 0, 60, 0};
    tbl[2]  = '{1'b0, 96'hFFFFFFFFFFFF_00A0C9123456, 16'h0806, 70, 8'h40, 0, 0, 0, 0, 78, 1};
    tbl[3]  = '{1'b1, 96'h0A0B0C0D0E0F_112233445566, 16'h0800, 10, 8'hA0, 0, 0, 0, 0, 24, 0};
    tbl[4]  = '{1'b0, 96'h0A0B0C0D0E0F_112233445566, 16'h0800, 46, 8'h00, 1, 1, 0, 0, 60, 0};
    tbl[5]  = '{1'b0, 96'h111111111111_222222222222, 16'h86DD, 20, 8'h30, 1, 1, 0, 0, 60, 0};
    tbl[6]  = '{1'b0, 96'h123456789ABC_DEF012345678, 16'h0800, 70, 8'h80, 1, 1, 0, 0, 78, 1};
    tbl[7]  = '{1'b0, 96'hA1A2A3A4A5A6_B1B2B3B4B5B6, 16'h0800, 64, 8'h10, 0, 0, 0, 0, 78, 0};
    tbl[8]  = '{1'b0, 96'hC0C1C2C3C4C5_D0D1D2D3D4D5, 16'h002E, 45, 8'hC0, 0, 1, 0, 0, 60, 0};
    tbl[9]  = '{1'b0, 96'hC0C1C2C3C4C5_D0D1D2D3D4D5, 16'h002F, 47, 8'hC0, 1, 0, 0, 0, 61, 0};
    tbl[10] = '{1'b0, 96'h5A5A5A5A5A5A_A5A5A5A5A5A5, 16'h0800, 46, 8'h01, 0, 0, 1, 0, 60, 0};
    tbl[11] = '{1'b0, 96'h0A0B0C0D0E0F_112233445566, 16'h0800, 46, 8'h55, 0, 0, 0, 1, 60, 0};
    tbl[12] = '{1'b1, 96'h0011223344AA_5566778899BB, 16'h0032, 50, 8'h70, 1, 1, 0, 0, 64, 0};

    rst_n = 1'b0; start = 1'b0; sel = 1'b0; tx_address = '0; ether_type = '0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs_a", {m_tvalid_a, m_tlast_a, m_tdata_a, s_tready_a, busy_a, done_a, err_a}, '0);
    chk("reset_outputs_b", {m_tvalid_b, m_tlast_b, m_tdata_b, s_tready_b, busy_b, done_b, err_b}, '0);
    chk("reset_state", 32'(state_a), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      run_frame(tbl[i], 0);
      idle_check();
    end

    // Back-to-back: second start raised in the done cycle of the first.
    run_frame(tbl[0], 0);
    run_frame(tbl[1], 0);
    idle_check();

    // Asynchronous reset at payload byte 5, then a clean frame.
    run_frame(tbl[0], 19);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    run_frame(tbl[2], 0);
    idle_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
